// File: rtl/mul_add_driver.sv
// Operand sequencer and result checker for a pipelined multiply-accumulate datapath.
// Optional LFSR operand source is enabled by defining MUL_ADD_DRIVER_LFSR_EN.
module mul_add_driver #(
  parameter int unsigned        p_nbits       = 32,
  parameter int unsigned        p_depth       = 8,
  parameter int unsigned        p_latency     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [$clog2(p_depth)-1:0] i_wr_addr,
  input  logic [p_nbits-1:0]         i_wr_a,
  input  logic [p_nbits-1:0]         i_wr_b,
  input  logic [$clog2(p_depth):0]   i_len,
  input  logic                       i_start,
  input  logic                       i_step,
`ifdef MUL_ADD_DRIVER_LFSR_EN
  input  logic                       i_lfsr_mode,
`endif
  output logic [p_nbits-1:0]         o_a,
  output logic [p_nbits-1:0]         o_b,
  input  logic [p_nbits-1:0]         i_dut_out,
  output logic [p_nbits-1:0]         o_exp_out,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [7:0]                 o_err_count
);

  localparam int unsigned c_aw = $clog2(p_depth);
  localparam int unsigned c_lw = c_aw + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

  state_t             r_state, w_state_d;
  logic [p_nbits-1:0] r_tab_a [p_depth];
  logic [p_nbits-1:0] r_tab_b [p_depth];
  logic [c_lw-1:0]    r_len, r_issue_cnt, r_cmp_cnt, w_len_clamped;
  logic [p_nbits-1:0] r_acc, r_a, r_b, r_exp;
  logic [p_nbits-1:0] r_dly [p_latency];
  logic [p_latency-1:0] r_dly_v;
  logic               r_err;
  logic [7:0]         r_err_count;
  logic [p_nbits-1:0] w_op_a, w_op_b, w_acc_next;
  logic [2*p_nbits-1:0] w_prod;
  logic               w_issue, w_adv, w_cmp;

`ifdef MUL_ADD_DRIVER_LFSR_EN
  logic               r_lfsr_mode;
  logic [p_nbits-1:0] r_lfsr_a, r_lfsr_b;
  logic               w_fb_a, w_fb_b;
  assign w_fb_a = r_lfsr_a[p_nbits-1] ^ r_lfsr_a[p_nbits-2];
  assign w_fb_b = r_lfsr_b[p_nbits-1] ^ r_lfsr_b[p_nbits-2];
  assign w_op_a = r_lfsr_mode ? r_lfsr_a : r_tab_a[r_issue_cnt[c_aw-1:0]];
  assign w_op_b = r_lfsr_mode ? r_lfsr_b : r_tab_b[r_issue_cnt[c_aw-1:0]];
`else
  assign w_op_a = r_tab_a[r_issue_cnt[c_aw-1:0]];
  assign w_op_b = r_tab_b[r_issue_cnt[c_aw-1:0]];
`endif

  assign w_len_clamped = (i_len > c_lw'(p_depth)) ? c_lw'(p_depth) : i_len;
  // Full-width product, truncated: only the low half can affect the mod-2^n sum.
  assign w_prod     = {{p_nbits{1'b0}}, w_op_a} * {{p_nbits{1'b0}}, w_op_b};
  assign w_acc_next = r_acc + w_prod[p_nbits-1:0];
  assign w_issue    = i_step && (r_state == StRun);
  assign w_adv      = i_step && (r_state == StRun || r_state == StDrain);
  assign w_cmp      = w_adv && r_dly_v[p_latency-1];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = (w_len_clamped == '0) ? StDone : StRun;
      StRun:   if (w_issue && r_issue_cnt == r_len - c_lw'(1)) w_state_d = StDrain;
      StDrain: if (w_cmp && r_cmp_cnt == r_len - c_lw'(1)) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
    endcase
  end

  // Table is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_wr_en && r_state == StIdle) begin
      r_tab_a[i_wr_addr] <= i_wr_a;
      r_tab_b[i_wr_addr] <= i_wr_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_cmp_cnt   <= '0;
      r_acc       <= '0;
      r_a         <= p_reset_value;
      r_b         <= p_reset_value;
      r_exp       <= p_reset_value;
      r_dly_v     <= '0;
      for (int i = 0; i < p_latency; i++) r_dly[i] <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
`ifdef MUL_ADD_DRIVER_LFSR_EN
      r_lfsr_mode <= 1'b0;
      r_lfsr_a    <= p_nbits'(1);
      r_lfsr_b    <= p_nbits'(2);
`endif
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && i_start) begin
        r_len       <= w_len_clamped;
        r_issue_cnt <= '0;
        r_cmp_cnt   <= '0;
        r_acc       <= '0;
        r_dly_v     <= '0;
        r_err       <= 1'b0;
        r_err_count <= '0;
`ifdef MUL_ADD_DRIVER_LFSR_EN
        r_lfsr_mode <= i_lfsr_mode;
        r_lfsr_a    <= p_nbits'(1);
        r_lfsr_b    <= p_nbits'(2);
`endif
      end
      if (w_issue) begin
        r_a         <= w_op_a;
        r_b         <= w_op_b;
        r_acc       <= w_acc_next;
        r_issue_cnt <= r_issue_cnt + c_lw'(1);
`ifdef MUL_ADD_DRIVER_LFSR_EN
        r_lfsr_a    <= {r_lfsr_a[p_nbits-2:0], w_fb_a};
        r_lfsr_b    <= {r_lfsr_b[p_nbits-2:0], w_fb_b};
`endif
      end
      if (w_adv) begin
        r_dly[0]   <= w_acc_next;
        r_dly_v[0] <= w_issue;
        for (int i = 1; i < p_latency; i++) begin
          r_dly[i]   <= r_dly[i-1];
          r_dly_v[i] <= r_dly_v[i-1];
        end
      end
      if (w_cmp) begin
        r_exp     <= r_dly[p_latency-1];
        r_cmp_cnt <= r_cmp_cnt + c_lw'(1);
        if (i_dut_out != r_dly[p_latency-1]) begin
          r_err <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_exp_out   = r_exp;
  assign o_busy      = (r_state == StRun) || (r_state == StDrain);
  assign o_done      = (r_state == StDone);
  assign o_err       = r_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_mul_add_driver.sv
// Self-checking bench for mul_add_driver: table-driven runs plus reset/abort/saturation sequences.
module tb_mul_add_driver;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, wr_en, start, step;
  logic [2:0]  wr_addr;
  logic [31:0] wr_a, wr_b, dut_out;
  logic [3:0]  len;
  logic [31:0] a, b, exp_out;
  logic        busy, done, err;
  logic [7:0]  err_count;

  logic        s_wr_en, s_start, s_step;
  logic [7:0]  s_wr_addr, s_wr_a, s_wr_b, s_dut_out;
  logic [8:0]  s_len;
  logic [7:0]  s_a, s_b, s_exp_out, s_err_count;
  logic        s_busy, s_done, s_err;

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_seen++;

  mul_add_driver #(.p_nbits(32), .p_depth(8), .p_latency(LAT), .p_reset_value('0)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_a(wr_a),
    .i_wr_b(wr_b), .i_len(len), .i_start(start), .i_step(step),
`ifdef MUL_ADD_DRIVER_LFSR_EN
    .i_lfsr_mode(1'b0),
`endif
    .o_a(a), .o_b(b), .i_dut_out(dut_out), .o_exp_out(exp_out), .o_busy(busy),
    .o_done(done), .o_err(err), .o_err_count(err_count)
  );

  mul_add_driver #(.p_nbits(8), .p_depth(256), .p_latency(LAT), .p_reset_value('0)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_wr_en(s_wr_en), .i_wr_addr(s_wr_addr), .i_wr_a(s_wr_a),
    .i_wr_b(s_wr_b), .i_len(s_len), .i_start(s_start), .i_step(s_step),
`ifdef MUL_ADD_DRIVER_LFSR_EN
    .i_lfsr_mode(1'b0),
`endif
    .o_a(s_a), .o_b(s_b), .i_dut_out(s_dut_out), .o_exp_out(s_exp_out), .o_busy(s_busy),
    .o_done(s_done), .o_err(s_err), .o_err_count(s_err_count)
  );

  typedef struct {
    int unsigned len;
    logic [31:0] a [8];
    logic [31:0] b [8];
    int          fault;
    logic [31:0] fault_val;
    bit          disturb;
    logic        exp_err;
    logic [7:0]  exp_cnt;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [5];
  logic [31:0] sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic run_vec(input int v);
    int n, d0;
    logic [31:0] acc, e;
    logic [63:0] p;
    logic [31:0] mdl [8];
    n = (vecs[v].len > 8) ? 8 : int'(vecs[v].len);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_a = vecs[v].a[i]; wr_b = vecs[v].b[i];
      tick();
    end
    wr_en = 1'b0;
    acc = '0;
    sb.delete();
    d0 = done_seen;
    start = 1'b1; len = 4'(vecs[v].len);
    tick();
    start = 1'b0;
    chk($sformatf("v%0d busy_at_start", v), busy, 1);
    for (int s = 1; s <= n + LAT; s++) begin
      step = 1'b1;
      if (s <= n) begin
        p = {32'b0, vecs[v].a[s-1]} * {32'b0, vecs[v].b[s-1]};
        acc = acc + p[31:0];
        mdl[s-1] = acc;
        sb.push_back(acc);
      end
      if (s > LAT) dut_out = (s - LAT - 1 == vecs[v].fault) ? vecs[v].fault_val : mdl[s-LAT-1];
      if (vecs[v].disturb && s == 2) begin
        start = 1'b1; len = 4'd1; wr_en = 1'b1; wr_addr = 3'd2; wr_a = 32'd77; wr_b = 32'd77;
      end
      tick();
      step = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (s <= n) begin
        chk($sformatf("v%0d a s%0d", v, s), a, vecs[v].a[s-1]);
        chk($sformatf("v%0d b s%0d", v, s), b, vecs[v].b[s-1]);
      end
      if (s > LAT) begin
        e = sb.pop_front();
        chk($sformatf("v%0d exp_out s%0d", v, s), exp_out, e);
      end
      if (s < n + LAT) chk($sformatf("v%0d busy s%0d", v, s), {busy, done}, 2'b10);
      else chk($sformatf("v%0d done_pulse", v), {busy, done}, 2'b01);
      tick();
    end
    chk($sformatf("v%0d done_low_after", v), done, 0);
    chk($sformatf("v%0d done_count", v), done_seen - d0, 1);
    chk($sformatf("v%0d err", v), err, vecs[v].exp_err);
    chk($sformatf("v%0d err_count", v), err_count, vecs[v].exp_cnt);
    chk($sformatf("v%0d exp_last", v), exp_out, vecs[v].exp_last);
    chk($sformatf("v%0d sb_empty", v), sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0].len = 5; vecs[0].a = '{1, 3, 10, 2, 5, 0, 0, 0}; vecs[0].b = '{2, 10, 1, 12, 13, 0, 0, 0};
    vecs[0].fault = -1; vecs[0].fault_val = 0; vecs[0].disturb = 0;
    vecs[0].exp_err = 0; vecs[0].exp_cnt = 0; vecs[0].exp_last = 32'd131;
    vecs[1] = vecs[0];
    vecs[1].fault = 1; vecs[1].fault_val = 32'd33; vecs[1].exp_err = 1; vecs[1].exp_cnt = 1;
    vecs[2].len = 2; vecs[2].a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
    vecs[2].b = vecs[2].a; vecs[2].fault = -1; vecs[2].fault_val = 0; vecs[2].disturb = 0;
    vecs[2].exp_err = 0; vecs[2].exp_cnt = 0; vecs[2].exp_last = 32'd2;
    vecs[3].len = 12; vecs[3].a = '{1, 2, 3, 4, 5, 6, 7, 8}; vecs[3].b = '{8, 7, 6, 5, 4, 3, 2, 1};
    vecs[3].fault = -1; vecs[3].fault_val = 0; vecs[3].disturb = 0;
    vecs[3].exp_err = 0; vecs[3].exp_cnt = 0; vecs[3].exp_last = 32'd120;
    vecs[4] = vecs[0];
    vecs[4].disturb = 1;

    reset = 1'b1; wr_en = 0; start = 0; step = 0; wr_addr = 0; wr_a = 0; wr_b = 0;
    dut_out = 0; len = 0;
    s_wr_en = 0; s_start = 0; s_step = 0; s_wr_addr = 0; s_wr_a = 0; s_wr_b = 0;
    s_dut_out = 0; s_len = 0;
    tick(); tick();
    chk("reset outputs", {a, b, exp_out, err_count, busy, done, err}, '0);
    reset = 1'b0;

    // Table survives a reset that lands on top of a write.
    wr_en = 1; wr_addr = 0; wr_a = 7; wr_b = 9; tick();
    wr_addr = 1; wr_a = 4; wr_b = 5; tick();
    wr_addr = 0; wr_a = 99; wr_b = 99; reset = 1'b1; tick(); tick();
    reset = 1'b0; wr_en = 0;
    chk("reset_mid_write outputs", {a[7:0], b[7:0], exp_out[7:0], err_count, busy, done, err},
        '0);
    start = 1; len = 4'd1; tick(); start = 0;
    step = 1; tick(); step = 0;
    chk("table_retained a", a, 7);
    chk("table_retained b", b, 9);
    reset = 1'b1; tick(); reset = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(v);

    d0 = done_seen;
    start = 1; len = 4'd0; tick(); start = 0;
    chk("len0 done", {busy, done}, 2'b01);
    tick();
    chk("len0 after", {busy, done}, 2'b00);
    chk("len0 one pulse", done_seen - d0, 1);

    // Abort on the third step: table still holds vecs[4] (basic) data.
    start = 1; len = 4'd5; tick(); start = 0;
    step = 1; tick(); step = 0; tick();
    step = 1; tick(); step = 0; tick();
    chk("abort pre a", a, 3);
    d0 = done_seen;
    step = 1; reset = 1; tick(); step = 0; reset = 0;
    chk("abort outputs", {a, b, exp_out, busy, done}, '0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort no done", done_seen - d0, 0);
    chk("abort busy", busy, 0);

    // Saturation: 256 mismatching compares in one run on a deep-table instance.
    for (int i = 0; i < 256; i++) begin
      s_wr_en = 1; s_wr_addr = 8'(i); s_wr_a = 0; s_wr_b = 0; tick();
    end
    s_wr_en = 0; s_dut_out = 8'd1;
    s_start = 1; s_len = 9'd256; tick(); s_start = 0;
    for (int s = 1; s <= 258; s++) begin
      s_step = 1; tick();
      if (s == 200) chk("sat count s200", s_err_count, 198);
      if (s == 257) chk("sat count s257", s_err_count, 255);
    end
    s_step = 0;
    chk("sat final count", s_err_count, 255);
    chk("sat err", s_err, 1);
    chk("sat done", {s_busy, s_done}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
